// File: rtl/mesm6_defines.sv
// mesm6_defines: shared bus controller types and address map constants
package mesm6_defines;
  localparam int AW = 15;
  localparam int DW = 48;
  localparam logic [5:0] IO_PAGE = 6'o77;
  localparam logic [11:0] SLOT_TOP = 12'o7777;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/mesm6_busdec.sv
// mesm6_busdec: combinational address decoder for RAM and I/O slots
module mesm6_busdec
  import mesm6_defines::*;
#(
  parameter int NDEV = 4
) (
  input  logic [14:3]     addr,
  output logic            sel_mem,
  output logic [NDEV-1:0] sel_dev,
  output logic            unmapped
);
  always_comb begin
    sel_mem = addr[14:9] != IO_PAGE;
    for (int k = 0; k < NDEV; k++) sel_dev[k] = addr == SLOT_TOP - 12'(k);
    unmapped = !sel_mem && sel_dev == '0;
  end
endmodule

// File: rtl/mesm6_busctl.sv
// mesm6_busctl: routes CPU requests to RAM or I/O slots with timeout, error capture and IRQ sampling
module mesm6_busctl
  import mesm6_defines::*;
#(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 255,
  parameter int NIRQ    = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_addr,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_done,
  output logic               cpu_err,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_done,
  output logic [AW-1:0]      dev_addr,
  output logic [DW-1:0]      dev_wdata,
  output logic [NDEV-1:0]    dev_read,
  output logic [NDEV-1:0]    dev_write,
  input  logic [DW*NDEV-1:0] dev_rdata,
  input  logic [NDEV-1:0]    dev_done,
  input  logic [NDEV-1:0]    dev_int,
  output logic [NIRQ-1:0]    pic_irq,
  output logic [AW-1:0]      err_addr
);
  state_t state, next;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, t_rdata;
  logic [11:0] cnt;
  logic [2:0] slot_q, slot;
  logic [NDEV-1:0] sel_dev, onehot;
  logic wr_q, mem_q, err_q, sel_mem, unmapped, req, bad, busy, expire, t_done;

  mesm6_busdec #(.NDEV(NDEV)) u_dec (
    .addr(cpu_addr[14:3]),
    .sel_mem(sel_mem),
    .sel_dev(sel_dev),
    .unmapped(unmapped)
  );

  // only the latched target's done/rdata are observed; other targets are ignored
  always_comb begin
    slot = '0;
    t_done = mem_q & mem_done;
    t_rdata = mem_rdata;
    for (int k = 0; k < NDEV; k++) begin
      if (sel_dev[k]) slot = 3'(k);
      if (!mem_q && slot_q == 3'(k)) begin
        t_done = dev_done[k];
        t_rdata = dev_rdata[DW*k +: DW];
      end
    end
    req = cpu_read | cpu_write;
    bad = unmapped | (cpu_read & cpu_write);
    busy = state == BUSY;
    expire = cnt == 12'(TIMEOUT - 1);
    next = state == IDLE ? (req ? (bad ? RESP : BUSY) : IDLE)
         : busy ? (t_done || expire ? RESP : BUSY) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end

  // done on the expiry cycle wins over the timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      cpu_rdata <= '0;
      err_addr <= '0;
      pic_irq <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      mem_q <= 1'b0;
      slot_q <= '0;
    end else begin
      pic_irq <= NIRQ'(dev_int);
      if (state == IDLE && req) begin
        addr_q <= cpu_addr;
        wdata_q <= cpu_wdata;
        wr_q <= cpu_write;
        mem_q <= sel_mem;
        slot_q <= slot;
        cnt <= '0;
        err_q <= bad;
        if (bad) begin
          cpu_rdata <= '0;
          err_addr <= cpu_addr;
        end
      end
      if (busy) begin
        cnt <= cnt + 12'd1;
        if (t_done) begin
          if (!wr_q) cpu_rdata <= t_rdata;
        end else if (expire) begin
          err_q <= 1'b1;
          cpu_rdata <= '0;
          err_addr <= addr_q;
        end
      end
    end
  end

  assign onehot = NDEV'(1) << slot_q;
  assign cpu_done = state == RESP;
  assign cpu_err = cpu_done & err_q;
  assign mem_addr = addr_q;
  assign dev_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign dev_wdata = wdata_q;
  assign mem_read = busy & mem_q & ~wr_q;
  assign mem_write = busy & mem_q & wr_q;
  assign dev_read = busy & ~mem_q & ~wr_q ? onehot : '0;
  assign dev_write = busy & ~mem_q & wr_q ? onehot : '0;
endmodule

// File: tb/tb_mesm6_busctl.sv
// tb_mesm6_busctl: randomized scoreboard bench with bus responders and a transaction-level reference model
module tb_mesm6_busctl;
  localparam int NDEV = 4;
  localparam int TMO = 8;
  localparam int NIRQ = 48;

  logic clk = 0, reset = 1;
  logic [14:0] cpu_addr = '0, mem_addr, dev_addr, err_addr;
  logic cpu_read = 0, cpu_write = 0, cpu_done, cpu_err;
  logic [47:0] cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata = '0, dev_wdata;
  logic mem_read, mem_write, mem_done = 0;
  logic [NDEV-1:0] dev_read, dev_write, dev_done = '0, dev_int = 4'b0101;
  logic [48*NDEV-1:0] dev_rdata = '0;
  logic [NIRQ-1:0] pic_irq;

  mesm6_busctl #(.NDEV(NDEV), .TIMEOUT(TMO), .NIRQ(NIRQ)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_read(dev_read), .dev_write(dev_write),
    .dev_rdata(dev_rdata), .dev_done(dev_done), .dev_int(dev_int), .pic_irq(pic_irq),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] rdata;
    logic        err;
    logic [14:0] eaddr;
    logic [14:0] addr;
    logic [47:0] wdata;
    logic        wr;
    int          tgt;
    int          done_cyc;
    int          strobes;
    int          issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0, lat_cfg = 1, run = 0, good_st = 0, bad_st = 0;
  bit hold_mon = 0;
  logic [47:0] ref_mem[logic [14:0]];
  logic [47:0] bus_mem[logic [14:0]];
  logic [47:0] ref_dev[NDEV];
  logic [47:0] bus_dev[NDEV];
  logic [47:0] last_rdata = '0;
  logic [14:0] last_eaddr = '0;
  logic [3:0] exp_irq = '0;

  function automatic logic [47:0] init_val(logic [14:0] a);
    return {3'b101, a, 15'h0, a};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic strobe_ok(exp_t e);
    logic [3:0] oh;
    oh = (e.tgt >= 0 && e.tgt < NDEV) ? 4'(1) << e.tgt : 4'b0;
    if (e.tgt == 4)
      return mem_read == !e.wr && mem_write == e.wr && dev_read == 0 && dev_write == 0 &&
             mem_addr == e.addr && (!e.wr || mem_wdata == e.wdata);
    if (e.tgt >= 0)
      return dev_read == (e.wr ? 4'b0 : oh) && dev_write == (e.wr ? oh : 4'b0) && !mem_read &&
             !mem_write && dev_addr == e.addr && (!e.wr || dev_wdata == e.wdata);
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_irq = reset ? 4'b0 : dev_int;
  end

  always @(negedge clk) dev_int = cyc < 30 ? 4'b0101 : 4'($urandom);

  // RAM and device responders: done after lat_cfg strobe cycles, random noise on unselected done lines
  always @(negedge clk) begin
    if (mem_read | mem_write | (|dev_read) | (|dev_write)) run++;
    else run = 0;
    mem_done = (mem_read | mem_write) ? run == lat_cfg : 1'($urandom);
    mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_val(mem_addr);
    if (mem_write && mem_done) bus_mem[mem_addr] = mem_wdata;
    for (int k = 0; k < NDEV; k++) begin
      dev_done[k] = (dev_read[k] | dev_write[k]) ? run == lat_cfg : 1'($urandom);
      dev_rdata[48*k +: 48] = bus_dev[k] ^ 48'(dev_addr);
      if (dev_write[k] && dev_done[k]) bus_dev[k] = dev_wdata;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) chk("pic_irq", pic_irq, 64'(exp_irq));
    if (!reset && !hold_mon) begin
      if (sb.size() > 0) begin
        if (mem_read | mem_write | (|dev_read) | (|dev_write)) begin
          if (strobe_ok(sb[0])) good_st++;
          else bad_st++;
        end
      end else chk("idle_strobe", {mem_read, mem_write, dev_read, dev_write}, 0);
      if (cpu_done) begin
        if (sb.size() == 0) chk("done_without_request", 64'(sb.size()), 1);
        else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc - mon_e.issue), 64'(mon_e.done_cyc));
          chk("cpu_err", cpu_err, mon_e.err);
          chk("cpu_rdata", cpu_rdata, mon_e.rdata);
          chk("err_addr", err_addr, mon_e.eaddr);
          chk("strobe_cycles", 64'(good_st), 64'(mon_e.strobes));
          chk("wrong_strobe", 64'(bad_st), 0);
          good_st = 0;
          bad_st = 0;
        end
      end
    end
  end

  // builds the expected response from the address map rules, then drives and holds the request
  task automatic issue(logic [14:0] a, logic rd, logic wr, logic [47:0] wd, int lat);
    exp_t e;
    int slot;
    logic mem;
    bit got;
    @(negedge clk);
    slot = -1;
    got = 0;
    for (int k = 0; k < NDEV; k++) if (a / 8 == 4095 - k) slot = k;
    mem = a / 512 != 63;
    e.addr = a;
    e.wdata = wd;
    e.wr = wr;
    e.issue = cyc;
    e.tgt = mem ? 4 : slot;
    if ((rd && wr) || (!mem && slot < 0)) begin
      e.tgt = -1;
      e.err = 1;
      e.done_cyc = 1;
      e.strobes = 0;
    end else if (lat >= 1 && lat <= TMO) begin
      e.err = 0;
      e.done_cyc = lat + 1;
      e.strobes = lat;
      if (wr) begin
        if (mem) ref_mem[a] = wd;
        else ref_dev[slot] = wd;
      end else last_rdata = mem ? (ref_mem.exists(a) ? ref_mem[a] : init_val(a)) : ref_dev[slot] ^ 48'(a);
    end else begin
      e.err = 1;
      e.done_cyc = TMO + 1;
      e.strobes = TMO;
    end
    if (e.err) begin
      last_rdata = '0;
      last_eaddr = a;
    end
    e.rdata = last_rdata;
    e.eaddr = last_eaddr;
    lat_cfg = lat;
    sb.push_back(e);
    cpu_addr = a;
    cpu_read = rd;
    cpu_write = wr;
    cpu_wdata = wd;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (cpu_done) got = 1;
    end
    cpu_read = 0;
    cpu_write = 0;
    if (!got) begin
      chk("done_within_bound", 64'(got), 1);
      sb.delete();
      good_st = 0;
      bad_st = 0;
    end
  endtask

  initial begin
    for (int k = 0; k < NDEV; k++) begin
      ref_dev[k] = 48'(k) * 48'h1111;
      bus_dev[k] = 48'(k) * 48'h1111;
    end
    repeat (3) @(negedge clk);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_strobes", {mem_read, mem_write, dev_read, dev_write}, 0);
    reset = 0;
    issue(15'o01234, 1, 0, 48'h0, 3);
    issue(15'o77770, 0, 1, 48'h123456789abc, 1);
    issue(15'o77770, 1, 0, 48'h0, 2);
    issue(15'o77600, 1, 0, 48'h0, 1);
    issue(15'o77761, 1, 0, 48'h0, 0);
    issue(15'o77773, 1, 0, 48'h0, TMO);
    issue(15'o00017, 1, 1, 48'h5, 1);
    @(negedge clk);
    hold_mon = 1;
    lat_cfg = 0;
    cpu_addr = 15'o77750;
    cpu_read = 1;
    repeat (3) @(negedge clk);
    chk("busy_strobe", dev_read, 4'b0100);
    reset = 1;
    cpu_read = 0;
    @(negedge clk);
    chk("rst_busy_strobes", {mem_read, mem_write, dev_read, dev_write}, 0);
    chk("rst_busy_done", cpu_done, 0);
    chk("rst_busy_rdata", cpu_rdata, 0);
    reset = 0;
    last_rdata = '0;
    last_eaddr = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("rst_no_done", cpu_done, 0);
    end
    hold_mon = 0;
    issue(15'o77750, 1, 0, 48'h0, 2);
    for (int i = 0; i < 300; i++) begin
      int r, m, rw, lat;
      logic [14:0] a;
      r = $urandom % 10;
      rw = $urandom % 16;
      m = $urandom % 12;
      a = r < 6 ? 15'($urandom_range(0, 15'o76777))
        : r < 9 ? {12'(4095 - ($urandom % NDEV)), 3'($urandom)}
        : {6'o77, 9'($urandom_range(0, 9'o737))};
      lat = m == 0 ? 0 : m == 1 ? TMO : 1 + $urandom % 4;
      issue(a, rw >= 0 && rw < 9, rw == 0 || rw >= 9, 48'({$urandom(), $urandom()}), lat);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mesm6_busctl.md
MESM6_BUSCTL -- requirements
Module: mesm6_busctl

Interface
REQ-001 Parameter NDEV, default 4, number of I/O device slots, range 1..8.
REQ-002 Parameter TIMEOUT, default 255, maximum BUSY cycles before bus error, range 1..4095.
REQ-003 Parameter NIRQ, default 48, width of pic_irq, NIRQ >= NDEV.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all state changes on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cpu_addr/cpu_read/cpu_write/cpu_wdata  in  15/1/1/48  CPU request; read and write are level signals held until cpu_done.
REQ-008 cpu_rdata/cpu_done/cpu_err  out  48/1/1  response data, one-cycle completion pulse, error flag valid with cpu_done.
REQ-009 mem_addr/mem_read/mem_write/mem_wdata  out  15/1/1/48  RAM request; mem_rdata/mem_done  in  48/1.
REQ-010 dev_addr/dev_wdata  out  15/48  shared device bus; dev_read/dev_write  out  NDEV each  per-slot strobes.
REQ-011 dev_rdata  in  48*NDEV  packed, slot k at [48k+47:48k]; dev_done  in  NDEV  per-slot completion.
REQ-012 dev_int  in  NDEV  device interrupt requests; pic_irq  out  NIRQ  registered interrupt vector.
REQ-013 err_addr  out  15  address of the most recent faulting transaction.

Function
REQ-014 Decode: slot k SHALL be selected when addr[14:3] == 12'o7777 - k; RAM when addr[14:9] != 6'o77; any other address is unmapped.
REQ-015 FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: on cpu_read or cpu_write, latch addr, wdata, direction and decoded target, then enter BUSY; an unmapped address, or read and write together, enters RESP with error and no strobe.
REQ-017 BUSY: drive the latched strobe to exactly one target, every cycle, until that target's done is sampled high; then capture its rdata and enter RESP.
REQ-018 RESP: cpu_done high for exactly one cycle, then IDLE; requests are not sampled in RESP.
REQ-019 Latency: request sampled at cycle 0, strobe visible at cycle 1, target done at cycle n >= 1, cpu_done at cycle n+1.
REQ-020 cpu_rdata SHALL hold the captured value from RESP until the next RESP; write responses leave it unchanged.
REQ-021 The timeout counter SHALL clear on BUSY entry, increment each BUSY cycle, and on reaching TIMEOUT drop the strobe and enter RESP with error.
REQ-022 On every error, cpu_err=1 with cpu_done, cpu_rdata=0, and err_addr = latched address.
REQ-023 Done in the same cycle as timeout expiry SHALL count as success.
REQ-024 done from a non-selected target SHALL be ignored.
REQ-025 Address and wdata outputs SHALL be driven from the latched copies, stable through BUSY.
REQ-026 pic_irq[k] = dev_int[k] registered once for k < NDEV, with all higher bits 0.

Reset
REQ-027 Reset SHALL set state IDLE and counter 0; all strobes, cpu_done and cpu_err to 0; cpu_rdata, err_addr and pic_irq to 0.
REQ-028 Reset during BUSY SHALL deassert all strobes on the next edge, with no cpu_done generated.

Structure
REQ-029 State enum, I/O page constant 6'o77 and the top slot base 12'o7777 SHALL live in mesm6_defines.sv (package).
REQ-030 The address decoder SHALL be a sub-module, mesm6_busdec, combinational, with outputs sel_mem, sel_dev[NDEV] and unmapped.

Verification
REQ-031 RAM read of 15'o01234 with mem_done at cycle 3 -> mem_read high for cycles 1-3; cpu_done at cycle 4 with mem_rdata and cpu_err=0.
REQ-032 Write to 15'o77770 (slot 0) with zero-wait done -> dev_write[0] for one cycle; cpu_done at cycle 2; no other strobe.
REQ-033 Read of 15'o77600 (unmapped, NDEV=4) -> no strobe; cpu_done at cycle 1 with cpu_err=1, cpu_rdata=0, err_addr=15'o77600.
REQ-034 TIMEOUT=8, slot 1 never done -> dev_read[1] cycles 1-8; cpu_done with cpu_err at cycle 9.
REQ-035 Reset asserted during BUSY -> strobes 0 on the next edge; no cpu_done; the next request completes normally.
REQ-036 dev_int=4'b0101 -> pic_irq[3:0]=4'b0101 one cycle later, with bits 47:4 equal to 0.
